// File: rtl/mul_error_stats.sv
// mul_error_stats: accumulates error count, signed/absolute error-distance sums and max error over a fixed-length run
module mul_error_stats #(
  parameter int W = 16,
  parameter int N_SAMPLES = 10000,
  parameter int CNT_W = 32,
  parameter int ACC_W = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     exact,
  input  logic [W-1:0]     apprx,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [ACC_W-1:0] sum_ed_abs,
  output logic [ACC_W-1:0] sum_ed,
  output logic [W-1:0]     max_ed
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] acc_q, acc_d, sample_cnt_q, sample_cnt_d, err_cnt_q, err_cnt_d;
  logic v1_q, v1_d, mis_q, mis_d;
  logic signed [W:0] d_q, d_d;
  logic [W-1:0] ad_q, ad_d, max_q, max_d;
  logic [ACC_W-1:0] sum_abs_q, sum_abs_d;
  logic signed [ACC_W-1:0] sum_q, sum_d, dx, ss;
  logic [CNT_W:0] sc_inc, ec_inc;
  logic [ACC_W:0] sa_inc;
  logic xfer, clr, last, ovf;
  assign in_ready = state_q == RUN;
  assign busy = state_q == RUN || state_q == DRAIN;
  assign done = state_q == DONE;
  assign xfer = in_valid && in_ready;
  assign clr = start && (state_q == IDLE || state_q == DONE);
  assign last = xfer && acc_q == CNT_W'(N_SAMPLES - 1);
  assign sample_cnt = sample_cnt_q;
  assign err_cnt = err_cnt_q;
  assign sum_ed_abs = sum_abs_q;
  assign sum_ed = sum_q;
  assign max_ed = max_q;
  always_comb begin
    state_d = clr ? RUN : last ? DRAIN : (state_q == DRAIN && !v1_q) ? DONE : state_q;
    acc_d = clr ? '0 : acc_q + CNT_W'(xfer);
    v1_d = xfer;
    d_d = xfer ? $signed({1'b0, exact}) - $signed({1'b0, apprx}) : d_q;
    ad_d = xfer ? (exact >= apprx ? exact - apprx : apprx - exact) : ad_q;
    mis_d = xfer ? exact != apprx : mis_q;
    sc_inc = {1'b0, sample_cnt_q} + (CNT_W+1)'(1);
    ec_inc = {1'b0, err_cnt_q} + (CNT_W+1)'(mis_q);
    sa_inc = {1'b0, sum_abs_q} + (ACC_W+1)'(ad_q);
    dx = ACC_W'(d_q);
    ss = sum_q + dx;
    ovf = sum_q[ACC_W-1] == dx[ACC_W-1] && ss[ACC_W-1] != sum_q[ACC_W-1];
    sample_cnt_d = clr ? '0 : !v1_q ? sample_cnt_q : sc_inc[CNT_W] ? '1 : sc_inc[CNT_W-1:0];
    err_cnt_d = clr ? '0 : !v1_q ? err_cnt_q : ec_inc[CNT_W] ? '1 : ec_inc[CNT_W-1:0];
    sum_abs_d = clr ? '0 : !v1_q ? sum_abs_q : sa_inc[ACC_W] ? '1 : sa_inc[ACC_W-1:0];
    sum_d = clr ? '0 : !v1_q ? sum_q : !ovf ? ss :
            sum_q[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    max_d = clr ? '0 : (v1_q && ad_q > max_q) ? ad_q : max_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q <= '0;
      v1_q <= 1'b0;
      d_q <= '0;
      ad_q <= '0;
      mis_q <= 1'b0;
      sample_cnt_q <= '0;
      err_cnt_q <= '0;
      sum_abs_q <= '0;
      sum_q <= '0;
      max_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      v1_q <= v1_d;
      d_q <= d_d;
      ad_q <= ad_d;
      mis_q <= mis_d;
      sample_cnt_q <= sample_cnt_d;
      err_cnt_q <= err_cnt_d;
      sum_abs_q <= sum_abs_d;
      sum_q <= sum_d;
      max_q <= max_d;
    end
  end
endmodule
